// File: rtl/clk_divider.sv
// ---------------------------------------------------------------------------
// clk_divider
//
// Integer clock divider that produces the UART bit clocks from the reference
// clock. The divide ratio N can be changed at runtime. A new ratio only takes
// effect at the end of the current divided period, so the output never
// produces a runt high or low phase.
//
// For N >= 2 a period is N clk cycles: floor(N/2) cycles high, followed by
// the rest low. Odd ratios therefore have one extra low cycle. A ratio of 0
// or 1 selects bypass, where the reference clock is passed straight through.
//
// Ports:
//   clk          reference clock; all state changes on its rising edge
//   reset        synchronous, active-high reset
//   i_clk_en     divider enable; 0 parks the divider with its output low
//   i_div_ratio  requested divide ratio N (0 and 1 select bypass)
//   o_div_clk    divided clock, or clk itself in bypass
//   o_tick       one-clk pulse on the first cycle of each divided high
//                phase; held at 1 in bypass
// ---------------------------------------------------------------------------
module clk_divider #(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clk_en,
    input  logic [RATIO_WIDTH-1:0] i_div_ratio,
    output logic                   o_div_clk,
    output logic                   o_tick
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [RATIO_WIDTH-1:0] RATIO_TWO = RATIO_WIDTH'(2);

    state_t                 state_q;
    state_t                 state_d;
    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] cnt_d;
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic [RATIO_WIDTH-1:0] ratio_d;
    logic                   div_q;
    logic                   div_d;
    logic                   tick_q;
    logic                   tick_d;

    logic                   run_q;
    logic                   bypass;
    logic                   new_ratio_divides;
    logic                   period_end;
    logic [RATIO_WIDTH-1:0] half;
    logic [RATIO_WIDTH-1:0] cnt_inc;
    logic [RATIO_WIDTH-1:0] ratio_last;

    // Derived terms used by the next-state logic. The ratio_last term wraps
    // when ratio_q < 2, but it is only consulted outside bypass. cnt_inc
    // cannot overflow, because the counter stops at ratio_q-1, which is at
    // most 2^RATIO_WIDTH-2.
    assign run_q             = (state_q == RUN);
    assign bypass            = run_q && (ratio_q < RATIO_TWO);
    assign new_ratio_divides = (i_div_ratio >= RATIO_TWO);
    assign half              = ratio_q >> 1;
    assign cnt_inc           = cnt + 1'b1;
    assign ratio_last        = ratio_q - 1'b1;
    assign period_end        = (cnt == ratio_last);

    // State register. Reset is sampled on the clock and overrides the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt     <= '0;
            ratio_q <= '0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
            ratio_q <= ratio_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic. The divider loads a new ratio in three situations:
    //   - when it leaves IDLE,
    //   - on every edge while in bypass,
    //   - at the end of a divided period.
    // Each load starts a fresh period. When the new ratio is 2 or more, the
    // high phase begins at that same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt;
        ratio_d = ratio_q;
        div_d   = div_q;
        tick_d  = tick_q;
        case (state_q)
            IDLE: begin
                if (i_clk_en) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ratio_d = i_div_ratio;
                    div_d   = new_ratio_divides;
                    tick_d  = new_ratio_divides;
                end
            end
            RUN: begin
                if (!i_clk_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    div_d   = 1'b0;
                    tick_d  = 1'b0;
                end else if (bypass || period_end) begin
                    cnt_d   = '0;
                    ratio_d = i_div_ratio;
                    div_d   = new_ratio_divides;
                    tick_d  = new_ratio_divides;
                end else begin
                    cnt_d   = cnt_inc;
                    div_d   = (cnt_inc < half);
                    tick_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // In bypass the reference clock is passed through combinationally, and
    // the tick is held high because every clk cycle is a divided cycle.
    assign o_div_clk = bypass ? clk : div_q;
    assign o_tick    = bypass | tick_q;

endmodule

// File: tb/tb_clk_divider.sv
// ---------------------------------------------------------------------------
// tb_clk_divider
//
// Self-checking bench for clk_divider. The reference model tracks two things:
//   - which clk edge started the current divided period, and
//   - which ratio that period uses.
// From those it computes the expected outputs with plain arithmetic:
//   - position = edges since the period started,
//   - high while position < N/2,
//   - tick when position == 0.
// Directed scenarios pin the model against hand-computed bit patterns. A
// randomized run then exercises reset, enable and ratio changes.
// ---------------------------------------------------------------------------
module tb_clk_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_clk_en;
    logic [7:0] i_div_ratio;
    logic       o_div_clk;
    logic       o_tick;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state.
    int   cyc     = 0;
    int   m_run   = 0;
    int   m_ratio = 0;
    int   m_start = 0;
    int   pos_old;
    int   pos;
    logic e_hi;
    logic e_lo;
    logic e_tick;

    clk_divider #(.RATIO_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_clk_en    (i_clk_en),
        .i_div_ratio (i_div_ratio),
        .o_div_clk   (o_div_clk),
        .o_tick      (o_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Drive the inputs on a falling edge. Return shortly after the next
    // rising edge, which is when the outputs can be inspected.
    task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] ratio);
        @(negedge clk);
        reset       = rst;
        i_clk_en    = en;
        i_div_ratio = ratio;
        @(posedge clk);
        #2;
    endtask

    // Apply n identical cycles. Shift each cycle's output bits into the
    // caller's vectors, oldest cycle in the most significant position.
    task automatic runAndCollect(input logic en, input logic [7:0] ratio, input int n,
                                 inout logic [15:0] div_bits, inout logic [15:0] tick_bits);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, en, ratio);
            div_bits  = {div_bits[14:0], o_div_clk};
            tick_bits = {tick_bits[14:0], o_tick};
        end
    endtask

    // Model update and comparison. Runs on every clk cycle.
    // Outputs are compared twice per cycle:
    //   - during the high half of clk, and
    //   - during the low half of clk.
    // Comparing in both halves checks that bypass really follows clk.
    initial begin
        forever begin
            @(posedge clk);
            pos_old = cyc - m_start;
            cyc++;
            if (reset === 1'b1) begin
                m_run   = 0;
                m_ratio = 0;
            end else if (m_run == 0) begin
                if (i_clk_en === 1'b1) begin
                    m_run   = 1;
                    m_ratio = int'(i_div_ratio);
                    m_start = cyc;
                end
            end else if (i_clk_en !== 1'b1) begin
                m_run = 0;
            end else if (m_ratio < 2 || pos_old == m_ratio - 1) begin
                m_ratio = int'(i_div_ratio);
                m_start = cyc;
            end
            pos = cyc - m_start;
            if (m_run != 0 && m_ratio < 2) begin
                e_hi   = 1'b1;
                e_lo   = 1'b0;
                e_tick = 1'b1;
            end else if (m_run != 0) begin
                e_hi   = (pos < m_ratio / 2);
                e_lo   = e_hi;
                e_tick = (pos == 0);
            end else begin
                e_hi   = 1'b0;
                e_lo   = 1'b0;
                e_tick = 1'b0;
            end
            #1;
            checkOutput("model div_clk (clk high)", o_div_clk, e_hi);
            checkOutput("model tick (clk high)", o_tick, e_tick);
            @(negedge clk);
            #1;
            checkOutput("model div_clk (clk low)", o_div_clk, e_lo);
            checkOutput("model tick (clk low)", o_tick, e_tick);
        end
    end

    // Directed scenarios with literal expectations, followed by random traffic.
    initial begin
        logic [15:0] dbits;
        logic [15:0] tbits;
        int          highs;
        int          ticks;
        int          hold;
        int          k;
        logic [7:0]  r;
        logic        rst;
        logic        en;

        reset       = 1'b1;
        i_clk_en    = 1'b1;
        i_div_ratio = 8'd4;

        // Hold reset with the divider enabled: both outputs must stay low.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 8'd4);
            checkOutput("reset div_clk", o_div_clk, 1'b0);
            checkOutput("reset tick", o_tick, 1'b0);
        end

        // Ratio 4: 2 high / 2 low, with a tick on each rising edge.
        dbits = '0; tbits = '0;
        runAndCollect(1'b1, 8'd4, 8, dbits, tbits);
        checkOutput("ratio4 div pattern", dbits, 16'h00CC);
        checkOutput("ratio4 tick pattern", tbits, 16'h0088);

        // Request ratio 8 at cnt=2 of a ratio-4 period. The current period
        // completes as 2/2, then the next period runs 4/4.
        dbits = '0; tbits = '0;
        runAndCollect(1'b1, 8'd4, 2, dbits, tbits);
        runAndCollect(1'b1, 8'd8, 10, dbits, tbits);
        checkOutput("ratio 4->8 div pattern", dbits, 16'h0CF0);
        checkOutput("ratio 4->8 tick pattern", tbits, 16'h0880);

        // Ratio 5: 2 high / 3 low.
        dbits = '0; tbits = '0;
        runAndCollect(1'b1, 8'd5, 10, dbits, tbits);
        checkOutput("ratio5 div pattern", dbits, 16'h0318);
        checkOutput("ratio5 tick pattern", tbits, 16'h0210);

        // Ratio 255: 127 high / 128 low. The counter must reach 254 without
        // wrapping, and the next period must start high.
        highs = 0; ticks = 0;
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd255);
            highs += int'(o_div_clk);
            ticks += int'(o_tick);
        end
        checkOutput("ratio255 high cycles", highs, 127);
        checkOutput("ratio255 ticks", ticks, 1);
        applyStimulus(1'b0, 1'b1, 8'd255);
        checkOutput("ratio255 next period div", o_div_clk, 1'b1);
        checkOutput("ratio255 next period tick", o_tick, 1'b1);

        // Disable, then re-enable in bypass with ratio 1 and then ratio 0.
        applyStimulus(1'b0, 1'b0, 8'd1);
        checkOutput("disable div_clk", o_div_clk, 1'b0);
        checkOutput("disable tick", o_tick, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd1);
        checkOutput("bypass1 div_clk follows clk", o_div_clk, 1'b1);
        checkOutput("bypass1 tick", o_tick, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0);
            checkOutput("bypass0 tick", o_tick, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 8'd1);

        // Switching from bypass to ratio 6 starts a 3/3 period at the next edge.
        dbits = '0; tbits = '0;
        runAndCollect(1'b1, 8'd6, 6, dbits, tbits);
        checkOutput("bypass->6 div pattern", dbits, 16'h0038);
        checkOutput("bypass->6 tick pattern", tbits, 16'h0020);

        // Drop the enable at cnt=2 of ratio 6, then re-enable.
        dbits = '0; tbits = '0;
        runAndCollect(1'b1, 8'd6, 3, dbits, tbits);
        checkOutput("ratio6 high before disable", dbits, 16'h0007);
        applyStimulus(1'b0, 1'b0, 8'd6);
        checkOutput("mid-period disable div_clk", o_div_clk, 1'b0);
        checkOutput("mid-period disable tick", o_tick, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd6);
        applyStimulus(1'b0, 1'b1, 8'd6);
        checkOutput("re-enable div_clk", o_div_clk, 1'b1);
        checkOutput("re-enable tick", o_tick, 1'b1);

        // Assert reset at cnt=3 of ratio 10, in the middle of the high phase.
        applyStimulus(1'b0, 1'b0, 8'd10);
        dbits = '0; tbits = '0;
        runAndCollect(1'b1, 8'd10, 4, dbits, tbits);
        checkOutput("ratio10 high before reset", dbits, 16'h000F);
        applyStimulus(1'b1, 1'b1, 8'd10);
        checkOutput("mid-high reset div_clk", o_div_clk, 1'b0);
        checkOutput("mid-high reset tick", o_tick, 1'b0);
        dbits = '0; tbits = '0;
        runAndCollect(1'b1, 8'd10, 10, dbits, tbits);
        checkOutput("post-reset ratio10 div pattern", dbits, 16'h03E0);
        checkOutput("post-reset ratio10 tick pattern", tbits, 16'h0200);

        // Random traffic. Ratios are held for random stretches so that some
        // periods complete and others are cut short. Reset is rare, and the
        // enable is usually high.
        hold = 0;
        r    = 8'd4;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                k = int'($urandom_range(0, 19));
                r = (k < 16) ? 8'(k) : 8'(255 - (k - 16));
                hold = int'($urandom_range(1, 40));
            end
            hold--;
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 29) != 0);
            applyStimulus(rst, en, r);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
